// File: rtl/munoc_slave_wburst_buffer_pkg.sv
// Shared definitions for the slave-side write-burst store-and-forward buffer.
//   - AXI address-channel sideband widths (len/size/burst)
//   - FSM state encoding (IDLE / CHECK / SEND_AW / SEND_W)
//   - helpers giving the packed entry widths of the AW and W FIFOs
package munoc_slave_wburst_buffer_pkg;

    localparam int BW_AXI_ALEN   = 8;
    localparam int BW_AXI_ASIZE  = 3;
    localparam int BW_AXI_ABURST = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_SEND_AW = 2'd2,
        ST_SEND_W  = 2'd3
    } wbuf_state_e;

    // AW entry: {id, addr, len, size, burst}
    function automatic int aw_entry_bits(input int bw_tid, input int bw_addr);
        return bw_tid + bw_addr + BW_AXI_ALEN + BW_AXI_ASIZE + BW_AXI_ABURST;
    endfunction

    // W entry: {id, data, strb, last}
    function automatic int w_entry_bits(input int bw_tid, input int bw_data);
        return bw_tid + bw_data + bw_data / 8 + 1;
    endfunction

endpackage

// File: rtl/munoc_wbuf_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used for the AW queue, the W beat
// buffer and the optional checker queues.
// Ports:
//   clk, rst         clock, synchronous active-high reset (empties the FIFO)
//   push, push_data  write request; ignored while full
//   pop              read request; ignored while empty
//   head             oldest entry, valid whenever empty is low
//   empty, full      occupancy flags
module munoc_wbuf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; only the pointers define which
    // entries are meaningful, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/munoc_slave_wburst_buffer.sv
// Store-and-forward write-burst buffer between the slave NI AXI write outputs
// and the AXI slave. Each AW is held until all of its W beats are buffered
// (or the W FIFO is full), so a slow NoC master never leaves the slave bus
// with a half-delivered burst. Read and B channels do not pass through here.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_aw*/s_awvalid/ready    upstream write address channel
//   s_w*/s_wvalid/ready      upstream write data channel
//   m_aw*/m_awvalid/ready    downstream write address channel
//   m_w*/m_wvalid/ready      downstream write data channel
//   wbuf_busy                FSM not idle or a FIFO holds data
//   wbuf_err                 (MUNOC_WBUF_CHECKER_EN only) sticky wlast/id error
// Build option: define MUNOC_WBUF_CHECKER_EN to add the wlast/id checker.
module munoc_slave_wburst_buffer
    import munoc_slave_wburst_buffer_pkg::*;
#(
    parameter int BW_AXI_TID = 4,
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 32,
    parameter int AW_DEPTH   = 2,
    parameter int W_DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BW_AXI_TID-1:0]    s_awid,
    input  logic [BW_ADDR-1:0]       s_awaddr,
    input  logic [BW_AXI_ALEN-1:0]   s_awlen,
    input  logic [BW_AXI_ASIZE-1:0]  s_awsize,
    input  logic [BW_AXI_ABURST-1:0] s_awburst,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [BW_AXI_TID-1:0]    s_wid,
    input  logic [BW_DATA-1:0]       s_wdata,
    input  logic [BW_DATA/8-1:0]     s_wstrb,
    input  logic                     s_wlast,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic [BW_AXI_TID-1:0]    m_awid,
    output logic [BW_ADDR-1:0]       m_awaddr,
    output logic [BW_AXI_ALEN-1:0]   m_awlen,
    output logic [BW_AXI_ASIZE-1:0]  m_awsize,
    output logic [BW_AXI_ABURST-1:0] m_awburst,
    output logic                     m_awvalid,
    input  logic                     m_awready,
    output logic [BW_AXI_TID-1:0]    m_wid,
    output logic [BW_DATA-1:0]       m_wdata,
    output logic [BW_DATA/8-1:0]     m_wstrb,
    output logic                     m_wlast,
    output logic                     m_wvalid,
    input  logic                     m_wready,
    output logic                     wbuf_busy
`ifdef MUNOC_WBUF_CHECKER_EN
    ,
    output logic                     wbuf_err
`endif
);

    localparam int AW_W   = aw_entry_bits(BW_AXI_TID, BW_ADDR);
    localparam int W_W    = w_entry_bits(BW_AXI_TID, BW_DATA);
    localparam int STRB_W = BW_DATA / 8;
    localparam int CNT_W  = $clog2(W_DEPTH) + 1;

    wbuf_state_e state, state_next;

    logic                     aw_push, aw_pop, aw_empty, aw_full;
    logic [AW_W-1:0]          aw_in, aw_head;
    logic                     w_push, w_pop, w_empty, w_full;
    logic [W_W-1:0]           w_in, w_head;

    logic [BW_AXI_TID-1:0]    h_awid;
    logic [BW_ADDR-1:0]       h_awaddr;
    logic [BW_AXI_ALEN-1:0]   h_awlen;
    logic [BW_AXI_ASIZE-1:0]  h_awsize;
    logic [BW_AXI_ABURST-1:0] h_awburst;
    logic [BW_AXI_TID-1:0]    hw_id;
    logic [BW_DATA-1:0]       hw_data;
    logic [STRB_W-1:0]        hw_strb;
    logic                     hw_last;

    logic [CNT_W-1:0]         beat_cnt;
    logic [31:0]              need_beats, have_beats;
    logic                     burst_ready;

    // ------------------------------------------------------------------
    // Upstream acceptance and FIFOs
    // ------------------------------------------------------------------
    assign s_awready = !rst && !aw_full;
    assign s_wready  = !rst && !w_full;
    assign aw_push   = s_awvalid && s_awready;
    assign w_push    = s_wvalid && s_wready;
    assign aw_pop    = (state == ST_SEND_AW) && m_awready;
    assign w_pop     = m_wvalid && m_wready;

    assign aw_in = {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst};
    assign w_in  = {s_wid, s_wdata, s_wstrb, s_wlast};

    assign {h_awid, h_awaddr, h_awlen, h_awsize, h_awburst} = aw_head;
    assign {hw_id, hw_data, hw_strb, hw_last}               = w_head;

    munoc_wbuf_sync_fifo #(.WIDTH(AW_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (aw_push),
        .push_data (aw_in),
        .pop       (aw_pop),
        .head      (aw_head),
        .empty     (aw_empty),
        .full      (aw_full)
    );

    munoc_wbuf_sync_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_in),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );

    // ------------------------------------------------------------------
    // Beat counter and FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            if (w_push && !w_pop)
                beat_cnt <= beat_cnt + CNT_W'(1);
            else if (!w_push && w_pop)
                beat_cnt <= beat_cnt - CNT_W'(1);
        end
    end

    // Release the head AW once its whole burst sits in the W FIFO. A full
    // FIFO also releases it, so bursts longer than the FIFO stream through.
    assign need_beats  = 32'(h_awlen) + 32'd1;
    assign have_beats  = 32'(beat_cnt);
    assign burst_ready = (need_beats <= have_beats) || w_full;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (!aw_empty)   state_next = ST_CHECK;
            ST_CHECK:   if (burst_ready) state_next = ST_SEND_AW;
            ST_SEND_AW: if (m_awready)   state_next = ST_SEND_W;
            ST_SEND_W:  if (w_pop && hw_last)
                            state_next = aw_empty ? ST_IDLE : ST_CHECK;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Downstream outputs are zero unless their valid is asserted.
    always_comb begin
        m_awvalid = 1'b0;
        m_awid    = '0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awsize  = '0;
        m_awburst = '0;
        m_wvalid  = 1'b0;
        m_wid     = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        if (state == ST_SEND_AW) begin
            m_awvalid = 1'b1;
            m_awid    = h_awid;
            m_awaddr  = h_awaddr;
            m_awlen   = h_awlen;
            m_awsize  = h_awsize;
            m_awburst = h_awburst;
        end
        if ((state == ST_SEND_W) && !w_empty) begin
            m_wvalid = 1'b1;
            m_wid    = hw_id;
            m_wdata  = hw_data;
            m_wstrb  = hw_strb;
            m_wlast  = hw_last;
        end
    end

    assign wbuf_busy = (state != ST_IDLE) || !aw_empty || !w_empty;

`ifdef MUNOC_WBUF_CHECKER_EN
    // ------------------------------------------------------------------
    // wlast / id checker. W may lead its AW, so completed W bursts are
    // summarised into one queue and accepted AWs into another; the heads
    // are compared whenever both queues hold an entry.
    // ------------------------------------------------------------------
    localparam int TRK_W = BW_AXI_TID + BW_AXI_ALEN;
    localparam int SCW   = BW_AXI_ALEN + 1;
    localparam int SUM_W = BW_AXI_TID + SCW + 1;

    logic                  trk_empty, trk_full, sum_empty, sum_full;
    logic [TRK_W-1:0]      trk_head;
    logic [SUM_W-1:0]      sum_in, sum_head;
    logic [BW_AXI_TID-1:0] trk_id, sum_id, cur_id, first_id;
    logic [BW_AXI_ALEN-1:0] trk_len;
    logic [SCW-1:0]        sum_cnt, cur_cnt, cnt_plus;
    logic                  sum_bad, cur_bad, id_bad, sum_push, match_pop, mismatch;

    assign {trk_id, trk_len}          = trk_head;
    assign {sum_id, sum_cnt, sum_bad} = sum_head;

    // Beat count saturates so an overlong burst still reports a mismatch.
    assign cnt_plus  = (&cur_cnt) ? cur_cnt : cur_cnt + SCW'(1);
    assign first_id  = (cur_cnt == '0) ? s_wid : cur_id;
    assign id_bad    = (cur_cnt != '0) && (s_wid != cur_id);
    assign sum_push  = w_push && s_wlast;
    assign sum_in    = {first_id, cnt_plus, cur_bad | id_bad};
    assign match_pop = !trk_empty && !sum_empty;
    assign mismatch  = sum_bad || (sum_id != trk_id) ||
                       (sum_cnt != ({1'b0, trk_len} + SCW'(1)));

    munoc_wbuf_sync_fifo #(.WIDTH(TRK_W), .DEPTH(2 * AW_DEPTH)) u_trk_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (aw_push),
        .push_data ({s_awid, s_awlen}),
        .pop       (match_pop),
        .head      (trk_head),
        .empty     (trk_empty),
        .full      (trk_full)
    );

    munoc_wbuf_sync_fifo #(.WIDTH(SUM_W), .DEPTH(W_DEPTH)) u_sum_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sum_push),
        .push_data (sum_in),
        .pop       (match_pop),
        .head      (sum_head),
        .empty     (sum_empty),
        .full      (sum_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_cnt  <= '0;
            cur_id   <= '0;
            cur_bad  <= 1'b0;
            wbuf_err <= 1'b0;
        end else begin
            if (w_push) begin
                if (s_wlast) begin
                    cur_cnt <= '0;
                    cur_bad <= 1'b0;
                end else begin
                    cur_cnt <= cnt_plus;
                    cur_id  <= first_id;
                    cur_bad <= cur_bad | id_bad;
                end
            end
            if (match_pop && mismatch) wbuf_err <= 1'b1;
        end
    end
`endif

endmodule
